// File: rtl/piano_pkg.sv
// Shared note definitions for the piano blocks: note encoding, tone FSM states and the
// equal-tempered period table. Pure definitions, no latency, no flow control.
package piano_pkg;

  localparam int NOTE_W    = 4;
  localparam int NUM_NOTES = 13;

  typedef enum logic [1:0] {IDLE, PLAY, DRAIN} tone_state_t;

  // C4..C5 in millihertz; the rounded integer ratio is exact enough for every table entry.
  function automatic longint note_period(input int code, input int clk_hz);
    longint f_mhz;
    case (code)
      0:       f_mhz = 64'd261626;
      1:       f_mhz = 64'd277183;
      2:       f_mhz = 64'd293665;
      3:       f_mhz = 64'd311127;
      4:       f_mhz = 64'd329628;
      5:       f_mhz = 64'd349228;
      6:       f_mhz = 64'd369994;
      7:       f_mhz = 64'd391995;
      8:       f_mhz = 64'd415305;
      9:       f_mhz = 64'd440000;
      10:      f_mhz = 64'd466164;
      11:      f_mhz = 64'd493883;
      12:      f_mhz = 64'd523251;
      default: f_mhz = 64'd0;
    endcase
    if (f_mhz == 64'd0) note_period = 64'd0;
    else note_period = (longint'(clk_hz) * 64'd1000 + f_mhz / 64'd2) / f_mhz;
  endfunction

endpackage

// File: rtl/tone_counter_if.sv
// Note-event inputs and counter/threshold outputs between the key decoder, the tone
// counter and the comparator. No flow control: strobes are single-cycle, outputs registered.
interface tone_counter_if #(parameter int N = 18) ();

  logic                        note_valid;
  logic [piano_pkg::NOTE_W-1:0] note_code;
  logic                        note_release;
  logic [N-1:0]                count;
  logic [N-1:0]                val;
  logic                        active;
  logic                        wrap;

  modport master (
    output note_valid, note_code, note_release,
    input  count, val, active, wrap
  );

  modport slave (
    input  note_valid, note_code, note_release,
    output count, val, active, wrap
  );

endinterface

// File: rtl/note_period_rom.sv
// Note code to period lookup, folded to constants at elaboration.
// Combinational, zero latency; no flow control. Codes >= NUM_NOTES report valid_code=0.
module note_period_rom import piano_pkg::*; #(
  parameter int N      = 18,
  parameter int CLK_HZ = 50_000_000
) (
  input  logic [NOTE_W-1:0] code,
  output logic [N-1:0]      period,
  output logic              valid_code
);

  logic [N-1:0] tbl [2**NOTE_W];

  for (genvar k = 0; k < 2**NOTE_W; k++) begin : g_tbl
    assign tbl[k] = N'(note_period(k, CLK_HZ));
  end

  always_comb begin
    valid_code = (code < NOTE_W'(NUM_NOTES));
    period     = '0;
    if (valid_code) period = tbl[code];
  end

endmodule

// File: rtl/tone_counter.sv
// Note events to free-running period counter plus 50% duty threshold for the comparator.
// Press in IDLE starts counting one cycle after the strobe; pitch changes and releases wait for the wrap.
module tone_counter import piano_pkg::*; #(
  parameter int N      = 18,
  parameter int CLK_HZ = 50_000_000
) (
  input  logic           clk,
  input  logic           reset,
  tone_counter_if.slave  bus
);

  tone_state_t  state, state_nxt;
  logic [N-1:0] count, count_nxt;
  logic [N-1:0] val, val_nxt;
  logic [N-1:0] period, period_nxt;
  logic [N-1:0] pend_period, pend_period_nxt;
  logic         pend_vld, pend_vld_nxt;
  logic         active, active_nxt;
  logic         wrap, wrap_nxt;
  logic [N-1:0] rom_period;
  logic         rom_valid;
  logic         press;
  logic         at_end;

  note_period_rom #(.N(N), .CLK_HZ(CLK_HZ)) u_rom (
    .code       (bus.note_code),
    .period     (rom_period),
    .valid_code (rom_valid)
  );

  assign press  = bus.note_valid & rom_valid;
  assign at_end = (state != IDLE) && (count == period - N'(1));

  always_comb begin
    state_nxt       = state;
    count_nxt       = count;
    val_nxt         = val;
    period_nxt      = period;
    pend_period_nxt = pend_period;
    pend_vld_nxt    = pend_vld;
    wrap_nxt        = 1'b0;
    case (state)
      IDLE: begin
        if (press) begin
          state_nxt  = PLAY;
          period_nxt = rom_period;
          val_nxt    = rom_period >> 1;
          count_nxt  = '0;
        end
      end
      PLAY, DRAIN: begin
        count_nxt = count + N'(1);
        if (at_end) begin
          count_nxt = '0;
          wrap_nxt  = 1'b1;
          if (pend_vld) begin
            period_nxt   = pend_period;
            val_nxt      = pend_period >> 1;
            pend_vld_nxt = 1'b0;
            state_nxt    = PLAY;
          end else if (state == DRAIN && !press) begin
            state_nxt  = IDLE;
            period_nxt = '0;
            val_nxt    = '0;
          end
        end
        // A press always wins over a release and revives a draining note.
        if (press) begin
          pend_period_nxt = rom_period;
          pend_vld_nxt    = 1'b1;
          state_nxt       = PLAY;
        end else if (bus.note_release && state == PLAY) begin
          state_nxt = DRAIN;
        end
      end
      default: state_nxt = IDLE;
    endcase
    active_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      count       <= '0;
      val         <= '0;
      period      <= '0;
      pend_period <= '0;
      pend_vld    <= 1'b0;
      active      <= 1'b0;
      wrap        <= 1'b0;
    end else begin
      state       <= state_nxt;
      count       <= count_nxt;
      val         <= val_nxt;
      period      <= period_nxt;
      pend_period <= pend_period_nxt;
      pend_vld    <= pend_vld_nxt;
      active      <= active_nxt;
      wrap        <= wrap_nxt;
    end
  end

  assign bus.count  = count;
  assign bus.val    = val;
  assign bus.active = active;
  assign bus.wrap   = wrap;

endmodule

// File: tb/tb_tone_counter.sv
// Bench for tone_counter: a scaled-clock instance for full-period scoreboarding and a
// default-parameter instance for the absolute 50 MHz table values.
module tb_tone_counter;

  localparam int S_CLK = 500_000;
  localparam int LIM   = 5000;

  logic       clk = 1'b0;
  logic       reset;
  logic       nv, nr;
  logic [3:0] nc;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {int period; int high;} exp_t;
  exp_t exp_q[$];

  tone_counter_if #(.N(18)) sif ();
  tone_counter_if #(.N(18)) bif ();

  assign sif.note_valid   = nv;
  assign sif.note_code    = nc;
  assign sif.note_release = nr;
  assign bif.note_valid   = nv;
  assign bif.note_code    = nc;
  assign bif.note_release = nr;

  tone_counter #(.N(18), .CLK_HZ(S_CLK)) u_small (.clk(clk), .reset(reset), .bus(sif));
  tone_counter #(.N(18), .CLK_HZ(50_000_000)) u_big (.clk(clk), .reset(reset), .bus(bif));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference period from the equal-tempered formula at the scaled clock.
  function automatic int mper(input int k);
    real f;
    f = 440.0 * (2.0 ** (real'(k - 9) / 12.0));
    return $rtoi(real'(S_CLK) / f + 0.5);
  endfunction

  task automatic push(input int k);
    exp_t e;
    e.period = mper(k);
    e.high   = mper(k) / 2;
    exp_q.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input int code);
    nv = 1'b1;
    nc = 4'(code);
    cyc();
    nv = 1'b0;
  endtask

  task automatic rel();
    nr = 1'b1;
    cyc();
    nr = 1'b0;
  endtask

  task automatic wait_cnt(input string tag, input int target);
    int n;
    n = 0;
    while (int'(sif.count) != target && n < LIM) begin
      cyc();
      n++;
    end
    if (n >= LIM) chk({tag, "_timeout"}, n, LIM - 1);
  endtask

  task automatic wait_wrap(input string tag);
    int n;
    n = 0;
    do begin
      cyc();
      n++;
    end while (sif.wrap !== 1'b1 && n < LIM);
    if (n >= LIM) chk({tag, "_timeout"}, n, LIM - 1);
  endtask

  // Scoreboard: every wrap closes one period; its length and high time are checked.
  int len  = 0;
  int high = 0;
  always @(negedge clk) begin
    if (reset) begin
      len  = 0;
      high = 0;
    end else begin
      if (sif.wrap) begin
        if (exp_q.size() == 0) begin
          chk("wrap_unexpected", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("period_len", len, e.period);
          chk("high_cycles", high, e.high);
        end
        len  = 0;
        high = 0;
      end
      if (sif.active) begin
        len++;
        if (sif.count < sif.val) high++;
      end
    end
  end

  task automatic chk_idle(input string tag);
    chk({tag, "_active"}, sif.active, 0);
    chk({tag, "_val"}, sif.val, 0);
    chk({tag, "_count"}, sif.count, 0);
  endtask

  initial begin
    int bad;
    reset = 1'b1;
    nv = 1'b0;
    nr = 1'b0;
    nc = 4'd0;
    repeat (3) cyc();
    chk("rst_count", sif.count, 0);
    chk("rst_val", sif.val, 0);
    chk("rst_active", sif.active, 0);
    chk("rst_wrap", sif.wrap, 0);
    chk("rst_big_count", bif.count, 0);
    reset = 1'b0;

    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      cyc();
      if (sif.count != 0 || sif.val != 0 || sif.active || sif.wrap ||
          bif.count != 0 || bif.val != 0 || bif.active || bif.wrap) bad++;
    end
    chk("idle_hold_bad_cycles", bad, 0);

    // Start A4, then queue C5 mid-way through the third period.
    push(9); push(9); push(9);
    press(9);
    chk("press_val", sif.val, mper(9) / 2);
    chk("press_count", sif.count, 0);
    chk("press_active", sif.active, 1);
    chk("big_a4_val", bif.val, 56818);
    cyc();
    chk("count_inc", sif.count, 1);
    wait_wrap("w1");
    wait_wrap("w2");
    wait_cnt("c500", 500);
    chk("big_count_run", bif.count, 2 * mper(9) + 500);
    push(12); push(12);
    press(12);
    chk("pend_val_held", sif.val, mper(9) / 2);
    chk("big_pend_val_held", bif.val, 56818);
    wait_wrap("w3");
    chk("apply_val", sif.val, mper(12) / 2);
    chk("apply_count", sif.count, 0);
    wait_wrap("w4");

    // Release mid-period: the note finishes its period before going quiet.
    wait_cnt("c300", 300);
    rel();
    chk("drain_active", sif.active, 1);
    wait_wrap("w5");
    chk_idle("rel_idle");
    cyc();
    chk("idle_count_held", sif.count, 0);

    // Invalid codes ignored; simultaneous press and release keeps playing.
    press(15);
    chk("inv_idle_active", sif.active, 0);
    chk("inv_idle_val", sif.val, 0);
    push(9); push(0);
    press(9);
    wait_cnt("c100", 100);
    press(15);
    chk("inv_play_val", sif.val, mper(9) / 2);
    wait_cnt("c400", 400);
    nv = 1'b1;
    nc = 4'd0;
    nr = 1'b1;
    cyc();
    nv = 1'b0;
    nr = 1'b0;
    chk("both_active", sif.active, 1);
    wait_wrap("w6");
    chk("both_apply_val", sif.val, mper(0) / 2);
    chk("both_still_play", sif.active, 1);
    wait_cnt("c100b", 100);
    rel();
    wait_wrap("w7");
    chk_idle("both_idle");

    // A press during DRAIN cancels the release and takes effect at the wrap.
    push(12); push(9);
    press(12);
    wait_cnt("c100c", 100);
    rel();
    wait_cnt("c200", 200);
    press(9);
    chk("revive_active", sif.active, 1);
    wait_wrap("w8");
    chk("revive_val", sif.val, mper(9) / 2);
    chk("revive_active_after", sif.active, 1);
    wait_cnt("c50", 50);
    rel();
    wait_wrap("w9");
    chk_idle("revive_idle");

    // Asynchronous reset in the middle of a draining note.
    press(0);
    wait_cnt("c100d", 100);
    rel();
    wait_cnt("c700", 700);
    #2;
    reset = 1'b1;
    exp_q.delete();
    #1;
    chk("arst_count", sif.count, 0);
    chk("arst_val", sif.val, 0);
    chk("arst_active", sif.active, 0);
    chk("arst_wrap", sif.wrap, 0);
    chk("arst_big_count", bif.count, 0);
    cyc();
    reset = 1'b0;
    cyc();
    push(0);
    press(0);
    chk("post_rst_val", sif.val, mper(0) / 2);
    chk("post_rst_count", sif.count, 0);
    chk("big_c4_val", bif.val, 95556);
    wait_cnt("c50b", 50);
    rel();
    wait_wrap("w10");
    chk_idle("final_idle");
    repeat (5) cyc();
    chk("queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
